// File: rtl/password_guard_ctrl_pkg.sv
// rtl/password_guard_ctrl_pkg.sv - state encodings and status LED codes for the password guard
package password_guard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_OPEN   = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ALARM  = 2'd3
    } guard_state_t;

    localparam logic [3:0] LED_ARMED  = 4'b0001;
    localparam logic [3:0] LED_OPEN   = 4'b0010;
    localparam logic [3:0] LED_LOCKED = 4'b0100;
    localparam logic [3:0] LED_ALARM  = 4'b1000;

    function automatic logic [3:0] state_led_of(guard_state_t s);
        case (s)
            ST_OPEN:   return LED_OPEN;
            ST_LOCKED: return LED_LOCKED;
            ST_ALARM:  return LED_ALARM;
            default:   return LED_ARMED;
        endcase
    endfunction

endpackage

// File: rtl/password_guard_ctrl_if.sv
// rtl/password_guard_ctrl_if.sv - event inputs and status outputs of the password guard
interface password_guard_ctrl_if;
    logic       tick;
    logic       attempt_ok;
    logic       attempt_fail;
    logic       admin_clr;
    logic       entry_en;
    logic       admitted;
    logic       locked;
    logic       alarm;
    logic [2:0] fail_count;
    logic [7:0] remaining;
    logic [3:0] state_led;

    modport master (
        output tick, attempt_ok, attempt_fail, admin_clr,
        input  entry_en, admitted, locked, alarm, fail_count, remaining, state_led
    );

    modport slave (
        input  tick, attempt_ok, attempt_fail, admin_clr,
        output entry_en, admitted, locked, alarm, fail_count, remaining, state_led
    );
endinterface

// File: rtl/password_guard_ctrl_tick_down_counter.sv
// rtl/password_guard_ctrl_tick_down_counter.sv - loadable 8-bit tick countdown shared by the open and lockout windows
module password_guard_ctrl_tick_down_counter (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       tick,
    output logic [7:0] count,
    output logic       done
);

    // Load beats tick so a freshly opened window starts at its full length.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 8'd0;
        end else if (clear) begin
            count <= 8'd0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && count != 8'd0) begin
            count <= count - 8'd1;
        end
    end

    assign done = tick && (count == 8'd1);

endmodule

// File: rtl/password_guard_ctrl.sv
// rtl/password_guard_ctrl.sv - supervisory FSM: open window, timed lockout and latched alarm
module password_guard_ctrl
    import password_guard_ctrl_pkg::*;
#(
    parameter int MAX_FAILS  = 3,
    parameter int LOCK_TICKS = 30,
    parameter int OPEN_TICKS = 12,
    parameter int MAX_LOCKS  = 2
) (
    input logic                 clk,
    input logic                 rst,
    password_guard_ctrl_if.slave bus
);

    guard_state_t state_q, state_d;
    logic [2:0]   fail_q, fail_d, fail_inc;
    logic [1:0]   lock_q, lock_d;
    logic         load;
    logic [7:0]   load_val;
    logic [7:0]   count;
    logic         win_done;
    logic         entry_en_q, admitted_q, locked_q, alarm_q;
    logic [3:0]   led_q;

    password_guard_ctrl_tick_down_counter u_window (
        .clk      (clk),
        .rst      (rst),
        .clear    (bus.admin_clr),
        .load     (load),
        .load_val (load_val),
        .tick     (bus.tick),
        .count    (count),
        .done     (win_done)
    );

    assign fail_inc = (fail_q == 3'(MAX_FAILS)) ? fail_q : fail_q + 3'd1;

    always_comb begin
        state_d  = state_q;
        fail_d   = fail_q;
        lock_d   = lock_q;
        load     = 1'b0;
        load_val = 8'd0;
        if (bus.admin_clr) begin
            state_d = ST_ARMED;
            fail_d  = 3'd0;
            lock_d  = 2'd0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    // A failure reported alongside a match takes precedence.
                    if (bus.attempt_fail) begin
                        fail_d = fail_inc;
                        if (fail_inc == 3'(MAX_FAILS)) begin
                            if (lock_q < 2'(MAX_LOCKS)) begin
                                state_d  = ST_LOCKED;
                                fail_d   = 3'd0;
                                lock_d   = lock_q + 2'd1;
                                load     = 1'b1;
                                load_val = 8'(LOCK_TICKS);
                            end else begin
                                state_d = ST_ALARM;
                            end
                        end
                    end else if (bus.attempt_ok) begin
                        state_d  = ST_OPEN;
                        fail_d   = 3'd0;
                        lock_d   = 2'd0;
                        load     = 1'b1;
                        load_val = 8'(OPEN_TICKS);
                    end
                end
                ST_OPEN, ST_LOCKED: begin
                    if (win_done) state_d = ST_ARMED;
                end
                ST_ALARM: begin
                    state_d = ST_ALARM;
                end
                default: begin
                    state_d = ST_ARMED;
                    fail_d  = 3'd0;
                    lock_d  = 2'd0;
                end
            endcase
        end
    end

    // Status flags are decoded from the next state so they change with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_ARMED;
            fail_q     <= 3'd0;
            lock_q     <= 2'd0;
            entry_en_q <= 1'b1;
            admitted_q <= 1'b0;
            locked_q   <= 1'b0;
            alarm_q    <= 1'b0;
            led_q      <= LED_ARMED;
        end else begin
            state_q    <= state_d;
            fail_q     <= fail_d;
            lock_q     <= lock_d;
            entry_en_q <= (state_d == ST_ARMED);
            admitted_q <= (state_d == ST_OPEN);
            locked_q   <= (state_d == ST_LOCKED);
            alarm_q    <= (state_d == ST_ALARM);
            led_q      <= state_led_of(state_d);
        end
    end

    assign bus.entry_en   = entry_en_q;
    assign bus.admitted   = admitted_q;
    assign bus.locked     = locked_q;
    assign bus.alarm      = alarm_q;
    assign bus.fail_count = fail_q;
    assign bus.remaining  = count;
    assign bus.state_led  = led_q;

endmodule

// File: tb/tb_password_guard_ctrl.sv
// tb/tb_password_guard_ctrl.sv - directed vector bench for password_guard_ctrl
module tb_password_guard_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    password_guard_ctrl_if bus ();

    password_guard_ctrl #(
        .MAX_FAILS  (3),
        .LOCK_TICKS (30),
        .OPEN_TICKS (12),
        .MAX_LOCKS  (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic       en;
        logic       adm;
        logic       lk;
        logic       al;
        logic [2:0] fc;
        logic [7:0] rem;
        logic [3:0] led;
    } outs_t;

    typedef struct {
        logic  ok;
        logic  fail;
        logic  tk;
        logic  clr;
        int    st;
        int    fc;
        int    rem;
        string name;
    } vec_t;

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[13];

    // st: 0 armed, 1 open, 2 locked, 3 alarm
    function automatic outs_t expect_of(int st, int fc, int rem);
        outs_t o;
        o.en  = (st == 0);
        o.adm = (st == 1);
        o.lk  = (st == 2);
        o.al  = (st == 3);
        o.fc  = 3'(fc);
        o.rem = 8'(rem);
        o.led = 4'(1 << st);
        return o;
    endfunction

    task automatic check(input string name, input outs_t exp);
        outs_t act;
        act = {bus.entry_en, bus.admitted, bus.locked, bus.alarm,
               bus.fail_count, bus.remaining, bus.state_led};
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h expected=%h (en,adm,lk,al,fc,rem,led)", name, act, exp);
    endtask

    task automatic step(input logic ok, input logic fail, input logic tk, input logic clr);
        @(negedge clk);
        bus.attempt_ok   = ok;
        bus.attempt_fail = fail;
        bus.tick         = tk;
        bus.admin_clr    = clr;
        @(posedge clk);
        #1;
        bus.attempt_ok   = 1'b0;
        bus.attempt_fail = 1'b0;
        bus.tick         = 1'b0;
        bus.admin_clr    = 1'b0;
    endtask

    task automatic wait_window(input string name, input int st, input int from, input int n);
        for (int i = 1; i <= n; i++) begin
            step(0, 0, 1, 0);
            if (from - i == 0) check(name, expect_of(0, 0, 0));
            else check(name, expect_of(st, 0, from - i));
        end
    endtask

    task automatic three_fails(input string name, input int final_st, input int final_fc, input int final_rem);
        step(0, 1, 0, 0);
        check({name, "_f1"}, expect_of(0, 1, 0));
        step(0, 1, 0, 0);
        check({name, "_f2"}, expect_of(0, 2, 0));
        step(0, 1, 0, 0);
        check({name, "_f3"}, expect_of(final_st, final_fc, final_rem));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{0, 0, 0, 0, 0, 0, 0,  "idle"};
        vecs[1]  = '{1, 0, 0, 0, 1, 0, 12, "ok_open"};
        vecs[2]  = '{0, 0, 1, 0, 1, 0, 11, "open_tick"};
        vecs[3]  = '{1, 1, 0, 0, 1, 0, 11, "open_ignore"};
        vecs[4]  = '{0, 0, 1, 1, 0, 0, 0,  "clr_prio"};
        vecs[5]  = '{0, 1, 0, 0, 0, 1, 0,  "fail1"};
        vecs[6]  = '{0, 0, 1, 0, 0, 1, 0,  "armed_tick"};
        vecs[7]  = '{0, 1, 0, 0, 0, 2, 0,  "fail2"};
        vecs[8]  = '{1, 1, 0, 0, 2, 0, 30, "both_fail_wins"};
        vecs[9]  = '{0, 0, 1, 0, 2, 0, 29, "lock_tick"};
        vecs[10] = '{0, 0, 0, 1, 0, 0, 0,  "clr_lock"};
        vecs[11] = '{1, 0, 1, 0, 1, 0, 12, "load_no_dec"};
        vecs[12] = '{0, 0, 0, 1, 0, 0, 0,  "clr_open"};

        bus.attempt_ok   = 1'b0;
        bus.attempt_fail = 1'b0;
        bus.tick         = 1'b0;
        bus.admin_clr    = 1'b0;
        #1 rst = 1'b0;
        #3 check("reset", expect_of(0, 0, 0));
        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[i])begin
            step(vecs[i].ok, vecs[i].fail, vecs[i].tk, vecs[i].clr);
            check(vecs[i].name, expect_of(vecs[i].st, vecs[i].fc, vecs[i].rem));
        end

        // full open window with one idle cycle in the middle
        step(1, 0, 0, 0);
        check("open_load", expect_of(1, 0, 12));
        wait_window("open_cnt", 1, 12, 6);
        step(0, 0, 0, 0);
        check("open_hold", expect_of(1, 0, 6));
        wait_window("open_cnt", 1, 6, 6);

        // first lockout, events ignored at remaining 17
        three_fails("lock1", 2, 0, 30);
        wait_window("lock1_cnt", 2, 30, 13);
        step(1, 1, 0, 0);
        check("lock_ignore", expect_of(2, 0, 17));
        wait_window("lock1_cnt", 2, 17, 17);

        // second lockout then alarm on the third
        three_fails("lock2", 2, 0, 30);
        wait_window("lock2_cnt", 2, 30, 30);
        three_fails("alarm", 3, 3, 0);
        step(0, 1, 0, 0);
        check("alarm_fail", expect_of(3, 3, 0));
        step(1, 0, 1, 0);
        check("alarm_ok_tick", expect_of(3, 3, 0));
        step(0, 0, 1, 0);
        check("alarm_tick", expect_of(3, 3, 0));
        step(0, 0, 0, 1);
        check("alarm_clr", expect_of(0, 0, 0));

        // lock history cleared: next three fails lock again rather than alarm
        three_fails("post_clr", 2, 0, 30);
        step(0, 0, 0, 1);
        check("post_clr_clr", expect_of(0, 0, 0));

        // asynchronous reset mid-window
        step(1, 0, 0, 0);
        wait_window("pre_rst", 1, 12, 7);
        @(negedge clk);
        #2 rst = 1'b0;
        #1 check("async_rst", expect_of(0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        step(0, 0, 1, 0);
        check("after_rst", expect_of(0, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
